// File: rtl/mul_div_seq_if.sv
// ---------------------------------------------------------------------------
// mul_div_seq_if
// Groups the operation request and result signals of the iterative
// multiply/divide unit into one bundle.
//   master : drives start, op_div, a, b; observes busy, done, hilo_we,
//            result, div_zero
//   slave  : the mul_div_seq unit itself
// Signals:
//   start     operation request, sampled only while the unit is idle
//   op_div    0 = multiply, 1 = divide (sampled with start)
//   a, b      two's complement operands
//   busy      high whenever the unit is not idle
//   done      one-cycle completion pulse
//   hilo_we   copy of done, load enable for the HI/LO register pair
//   result    {HI, LO}
//   div_zero  divide-by-zero flag (always 0 unless detection is built in)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface mul_div_seq_if #(parameter int WIDTH = 32);
  logic               start;
  logic               op_div;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic               hilo_we;
  logic [2*WIDTH-1:0] result;
  logic               div_zero;

  modport master (
    output start, op_div, a, b,
    input  busy, done, hilo_we, result, div_zero
  );

  modport slave (
    input  start, op_div, a, b,
    output busy, done, hilo_we, result, div_zero
  );
endinterface

// File: rtl/mul_div_seq.sv
// ---------------------------------------------------------------------------
// mul_div_seq
// Iterative signed WIDTH x WIDTH multiply and WIDTH / WIDTH divide. It is the
// writer side of the 64-bit HI/LO register: result carries {HI, LO} and
// hilo_we pulses for one cycle when a new value is ready.
//   Multiply : result = full signed product
//   Divide   : result = {remainder, quotient}, truncating division
//              (the remainder takes the dividend's sign)
// Sequence: IDLE -> PREP -> ITER (WIDTH cycles) -> FIX -> DONE -> IDLE
//
// Ports:
//   clk  rising-edge system clock
//   clr  asynchronous active-high reset
//   bus  mul_div_seq_if.slave (start/op_div/a/b in; busy/done/hilo_we/
//        result/div_zero out)
//
// Build option:
//   MULDIV_DIVZERO_DETECT_EN  when defined, a divide by zero skips the loop,
//   returns {a, all ones} straight from PREP and raises div_zero until the
//   next operation starts. When undefined div_zero is tied low and a divide
//   by zero runs the normal restoring loop.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mul_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          clr,
  mul_div_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t               state_q;
  logic                 opDiv_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     magA_q;
  logic [WIDTH-1:0]     magB_q;
  logic                 negQuo_q;
  logic                 negRem_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 busy_q;
  logic                 done_q;
`ifdef MULDIV_DIVZERO_DETECT_EN
  logic                 divZero_q;
`endif

  logic [WIDTH-1:0]     absA;
  logic [WIDTH-1:0]     absB;
  logic [WIDTH:0]       mulSum;
  logic [WIDTH:0]       remShift;
  logic [WIDTH-1:0]     remSub;
  logic [2*WIDTH-1:0]   accStep_d;

  // Operand magnitudes; the most negative value maps onto 2^(WIDTH-1)
  // unsigned, which still fits in WIDTH bits.
  assign absA = a_q[WIDTH-1] ? -a_q : a_q;
  assign absB = b_q[WIDTH-1] ? -b_q : b_q;

  // One iteration of the loop on the shared 2*WIDTH accumulator.
  // Multiply: acc = {partial product, remaining multiplier bits}; add the
  // multiplicand into the top half when the multiplier LSB is set, keeping
  // the carry so the right shift does not lose it.
  // Divide: acc = {remainder, quotient}; shift left, and if the shifted
  // remainder covers the divisor subtract it and shift a 1 into the quotient.
  // The shifted remainder keeps its carry-out bit so the compare stays exact.
  always_comb begin
    accStep_d = acc_q;
    mulSum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, magA_q};
    remShift  = acc_q[2*WIDTH-1:WIDTH-1];
    remSub    = remShift[WIDTH-1:0] - magB_q;
    if (opDiv_q) begin
      if (remShift >= {1'b0, magB_q}) begin
        accStep_d = {remSub, acc_q[WIDTH-2:0], 1'b1};
      end else begin
        accStep_d = {remShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else if (acc_q[0]) begin
      accStep_d = {mulSum, acc_q[WIDTH-1:1]};
    end else begin
      accStep_d = {1'b0, acc_q[2*WIDTH-1:1]};
    end
  end

  // Control state machine with registered outputs. done is a default-low
  // pulse raised only on the edge that enters DONE; result only changes on
  // that same edge and otherwise holds. A start seen outside IDLE is simply
  // dropped, so nothing is queued behind a running operation.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      opDiv_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      magA_q    <= '0;
      magB_q    <= '0;
      negQuo_q  <= 1'b0;
      negRem_q  <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MULDIV_DIVZERO_DETECT_EN
      divZero_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q       <= bus.a;
            b_q       <= bus.b;
            opDiv_q   <= bus.op_div;
            busy_q    <= 1'b1;
`ifdef MULDIV_DIVZERO_DETECT_EN
            divZero_q <= 1'b0;
`endif
            state_q   <= PREP;
          end
        end

        // The upper half of the accumulator starts at zero; the lower half
        // holds the multiplier (multiply) or the dividend (divide).
        PREP: begin
          magA_q   <= absA;
          magB_q   <= absB;
          negQuo_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
          negRem_q <= a_q[WIDTH-1];
          cnt_q    <= '0;
          acc_q    <= opDiv_q ? {{WIDTH{1'b0}}, absA} : {{WIDTH{1'b0}}, absB};
          state_q  <= ITER;
`ifdef MULDIV_DIVZERO_DETECT_EN
          if (opDiv_q && (b_q == '0)) begin
            result_q  <= {a_q, {WIDTH{1'b1}}};
            divZero_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
`endif
        end

        ITER: begin
          acc_q <= accStep_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end

        // Restore signs: product and quotient follow a^b, the remainder
        // follows the dividend.
        FIX: begin
          if (opDiv_q) begin
            result_q <= {negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH],
                         negQuo_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0]};
          end else begin
            result_q <= negQuo_q ? -acc_q : acc_q;
          end
          done_q  <= 1'b1;
          state_q <= DONE;
        end

        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hilo_we = done_q;
  assign bus.result  = result_q;
`ifdef MULDIV_DIVZERO_DETECT_EN
  assign bus.div_zero = divZero_q;
`else
  assign bus.div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mul_div_seq.sv
// ---------------------------------------------------------------------------
// tb_mul_div_seq
// Directed bench for mul_div_seq: reset behaviour, signed multiply, signed
// truncating divide, overflow, divide by zero, start handshake corner cases.
// Latency is counted as rising edges from the one that samples start
// (inclusive) to the cycle in which done is seen.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mul_div_seq;

  logic clk;
  logic clr;
  int   assertCount;
  int   failCount;

  int   edges;
  logic sawDone;
  logic weMis;
  int   firstDone;
  int   secondDone;
  int   doneCount;

  mul_div_seq_if #(.WIDTH(32)) bus ();

  mul_div_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts, asserts and reports on mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h, required %h", tag, observed, expected);
    end
  endtask

  // Launches one operation and waits (bounded) for done. Optionally pulses
  // start with different operands at edge count pulseAt while busy.
  task automatic applyStimulus(input logic opDiv, input logic [31:0] aIn,
                               input logic [31:0] bIn, input int pulseAt);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_div = opDiv;
    bus.a      = aIn;
    bus.b      = bIn;
    @(negedge clk);
    edges   = 1;
    sawDone = 1'b0;
    weMis   = 1'b0;
    while (!sawDone && edges < 100) begin
      if (bus.hilo_we !== bus.done) weMis = 1'b1;
      if (bus.done === 1'b1) begin
        sawDone = 1'b1;
      end else begin
        if (pulseAt != 0 && edges == pulseAt) begin
          bus.start  = 1'b1;
          bus.op_div = 1'b0;
          bus.a      = 32'd100;
          bus.b      = 32'd7;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        edges++;
      end
    end
    bus.start = 1'b0;
  endtask

  // Checks the completion cycle and the idle cycle after it.
  task automatic verifyOp(input string tag, input logic [63:0] expResult,
                          input int expEdges, input logic expDz);
    checkOutput({tag, "_done_seen"}, 64'(sawDone), 64'd1);
    checkOutput({tag, "_latency"}, 64'(edges), 64'(expEdges));
    checkOutput({tag, "_result"}, bus.result, expResult);
    checkOutput({tag, "_hilo_we_eq_done"}, 64'(weMis), 64'd0);
    checkOutput({tag, "_div_zero"}, 64'(bus.div_zero), 64'(expDz));
    @(negedge clk);
    checkOutput({tag, "_done_one_cycle"}, 64'(bus.done), 64'd0);
    checkOutput({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
    checkOutput({tag, "_result_hold"}, bus.result, expResult);
    checkOutput({tag, "_div_zero_hold"}, 64'(bus.div_zero), 64'(expDz));
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    bus.start   = 1'b0;
    bus.op_div  = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    clr         = 1'b1;

    // Reset state.
    #3;
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    checkOutput("reset_hilo_we", 64'(bus.hilo_we), 64'd0);
    checkOutput("reset_result", bus.result, 64'd0);
    checkOutput("reset_div_zero", 64'(bus.div_zero), 64'd0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;

    // clr in the middle of 6*7: operation is discarded, no done pulse.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_div = 1'b0;
    bus.a      = 32'd6;
    bus.b      = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("midop_busy_before_clr", 64'(bus.busy), 64'd1);
    #2 clr = 1'b1;
    #1;
    checkOutput("midop_clr_busy", 64'(bus.busy), 64'd0);
    checkOutput("midop_clr_result", bus.result, 64'd0);
    checkOutput("midop_clr_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    clr = 1'b0;
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done !== 1'b0) sawDone = 1'b1;
    end
    checkOutput("midop_no_done", 64'(sawDone), 64'd0);
    checkOutput("midop_still_idle", 64'(bus.busy), 64'd0);

    // Multiplies.
    applyStimulus(1'b0, 32'd6, 32'd7, 0);
    verifyOp("mul_6x7", 64'h0000_0000_0000_002A, 35, 1'b0);
    applyStimulus(1'b0, 32'hFFFF_FFFD, 32'd5, 0);
    verifyOp("mul_m3x5", 64'hFFFF_FFFF_FFFF_FFF1, 35, 1'b0);
    applyStimulus(1'b0, 32'h8000_0000, 32'h8000_0000, 0);
    verifyOp("mul_min_sq", 64'h4000_0000_0000_0000, 35, 1'b0);

    // Divides: result = {remainder, quotient}.
    applyStimulus(1'b1, 32'd17, 32'd5, 0);
    verifyOp("div_17_5", {32'h0000_0002, 32'h0000_0003}, 35, 1'b0);
    applyStimulus(1'b1, 32'hFFFF_FFEF, 32'd5, 0);
    verifyOp("div_m17_5", {32'hFFFF_FFFE, 32'hFFFF_FFFD}, 35, 1'b0);
    applyStimulus(1'b1, 32'd17, 32'hFFFF_FFFB, 0);
    verifyOp("div_17_m5", {32'h0000_0002, 32'hFFFF_FFFD}, 35, 1'b0);
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    verifyOp("div_overflow", {32'h0000_0000, 32'h8000_0000}, 35, 1'b0);

    // Divide by zero: with detection PREP goes straight to DONE, so done is
    // seen after the sampling edge plus one more.
`ifdef MULDIV_DIVZERO_DETECT_EN
    applyStimulus(1'b1, 32'hFFFF_FFF6, 32'd0, 0);
    verifyOp("div_zero", {32'hFFFF_FFF6, 32'hFFFF_FFFF}, 2, 1'b1);
`else
    applyStimulus(1'b1, 32'hFFFF_FFF6, 32'd0, 0);
    verifyOp("div_zero", {32'hFFFF_FFF6, 32'h0000_0001}, 35, 1'b0);
`endif
    // A following operation clears any divide-by-zero flag.
    applyStimulus(1'b0, 32'hFFFF_FFFD, 32'd5, 0);
    verifyOp("mul_after_dz", 64'hFFFF_FFFF_FFFF_FFF1, 35, 1'b0);

    // start pulsed while busy with other operands: ignored, not queued.
    applyStimulus(1'b1, 32'd17, 32'd5, 5);
    verifyOp("busy_pulse", {32'h0000_0002, 32'h0000_0003}, 35, 1'b0);
    @(negedge clk);
    checkOutput("busy_pulse_not_queued", 64'(bus.busy), 64'd0);

    // start held high: back-to-back operations every 36 cycles.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_div = 1'b0;
    bus.a      = 32'd6;
    bus.b      = 32'd7;
    edges      = 0;
    doneCount  = 0;
    firstDone  = 0;
    secondDone = 0;
    while (doneCount < 2 && edges < 200) begin
      @(negedge clk);
      edges++;
      if (bus.done === 1'b1) begin
        doneCount++;
        if (doneCount == 1) firstDone = edges;
        else secondDone = edges;
      end
    end
    bus.start = 1'b0;
    checkOutput("held_two_dones", 64'(doneCount), 64'd2);
    checkOutput("held_first_latency", 64'(firstDone), 64'd35);
    checkOutput("held_period", 64'(secondDone - firstDone), 64'd36);
    @(negedge clk);
    checkOutput("held_idle_after_release", 64'(bus.busy), 64'd0);
    checkOutput("held_result", bus.result, 64'h0000_0000_0000_002A);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
